sram_pattern_gen: RTL and testbench
===================================

# sram_pattern_gen

Address-sweep pattern sequencer that sits directly upstream of the registered SRAM wrapper (sram22_64x4m4w2 macro behind one input register stage) and drives its we/wmask/addr/din. It also consumes the wrapper's dout. On a start command it writes a deterministic data pattern to every address, reads every address back, and checks the returned data. It reports an error count and the first failing address, and is used to generate repeatable access activity for energy characterization.

## Interface
- DATA_WIDTH, 4, SRAM word width
- ADDR_WIDTH, 6, SRAM address width; depth = 2^ADDR_WIDTH
- WMASK_WIDTH, 2, write-mask width
- READ_LATENCY, 2, cycles from this block presenting a read address to the matching dout being valid at its input (wrapper register plus macro); legal range 1..8
- clock  input  1  rising-edge clock shared with the SRAM wrapper
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a run; ignored while busy=1
- mode  input  2  sampled with start: 0 = write-only, 1 = read-only, 2 and 3 = write-then-read
- seed  input  DATA_WIDTH  sampled with start; pattern key
- we  output  1  write enable to the wrapper
- wmask  output  WMASK_WIDTH  write mask to the wrapper
- addr  output  ADDR_WIDTH  address to the wrapper
- din  output  DATA_WIDTH  write data to the wrapper
- dout  input  DATA_WIDTH  read data from the wrapper
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse at the end of a run
- err_count  output  ADDR_WIDTH+1  number of read mismatches in the current run; saturates at all-ones
- err_flag  output  1  high once any mismatch is seen in the current run
- first_err_addr  output  ADDR_WIDTH  address of the first mismatch; holds 0 until an error occurs

## Operation
- Pattern: pat(a) = seed XOR a[DATA_WIDTH-1:0]. If ADDR_WIDTH < DATA_WIDTH, a is zero-extended.
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - Outputs we=0, wmask=0, addr=0, din=0.
  - start=1 latches mode and seed, clears err_count, err_flag and first_err_addr, and moves to WRITE (mode 0/2/3) or READ (mode 1).
- WRITE:
  - Each cycle drives we=1, wmask all ones, addr=a, din=pat(a), with a counting 0 .. 2^ADDR_WIDTH-1.
  - After the last address: mode 0 goes to DONE; mode 2/3 goes to READ with a restarting at 0.
- READ:
  - Each cycle drives we=0, wmask=0, din=0, addr=a, with a counting 0 .. 2^ADDR_WIDTH-1.
  - Each cycle pushes {valid=1, a, pat(a)} into a READ_LATENCY-deep shift pipeline.
  - After the last address, goes to DRAIN.
- DRAIN:
  - Drives idle outputs and pushes valid=0 into the pipeline.
  - Stays for exactly READ_LATENCY cycles, then goes to DONE.
- DONE: asserts done for one cycle, then returns to IDLE.
- Check: every cycle the pipeline output has valid=1, dout is compared with the expected value.
  - On mismatch, err_count increments (saturating).
  - On the first mismatch of the run, err_flag is set and first_err_addr captures the address.
- The address counter wraps naturally. The terminal condition is a == all-ones in the current state, not the wrap.
- A start arriving while busy=1 or in DONE is dropped.
- Result outputs hold their values in IDLE until the next accepted start or reset.

## Timing
- Reset values: we=0, wmask=0, addr=0, din=0, busy=0, done=0, err_count=0, err_flag=0, first_err_addr=0. FSM goes to IDLE and the pipeline valids are cleared.
- Reset mid-run: the run aborts the next cycle with no done pulse. The SRAM contents are not restored.
- All outputs are registered. start accepted at edge N gives busy=1 and the first command on we/addr/din after edge N.
- Write-then-read run length from start to the done pulse: 2·2^ADDR_WIDTH + READ_LATENCY + 1 cycles of busy, then done.
  - Defaults: 64 + 64 + 2 + 1 = 131 cycles.
- The last write and the first read are on consecutive cycles with no bubble.
- busy falls in the same cycle done pulses.

## Test plan
- Reset mid-READ (cycle 20 of the read sweep) → next cycle all outputs are at reset values, no done pulse; a subsequent start runs cleanly.
- Defaults with a behavioural 64x4 memory model at READ_LATENCY=2, mode=2, seed=4'hA → 64 writes with din(a) = 4'hA ^ a[3:0], 64 reads, done exactly 131 cycles after start, err_count=0, err_flag=0.
- Same run with the model forcing a bit-flip at addresses 5 and 40 → err_count=2, err_flag=1, first_err_addr=5.
- mode=0, seed=3 then mode=1, seed=3 → the read-only run reports 0 errors; repeating with mode=1, seed=4 → err_count=64, err_flag=1, first_err_addr=0.
- start held high for the full run plus pulses during DONE → exactly one run, one done pulse, no re-trigger until back in IDLE.
- Stuck-at-0 model over a run with ADDR_WIDTH=3, READ_LATENCY=5 → err_count equals the count of nonzero patterns; done arrives 2·8+5+1=22 cycles after start; err_count never wraps.

Source files
------------

// File: rtl/sram_pattern_gen.sv
// Address-sweep pattern sequencer for the registered SRAM wrapper: writes pat(a) = seed ^ a
// to every address, reads it back through a latency-matched expect pipeline and counts mismatches.
module sram_pattern_gen #(
    parameter int unsigned DATA_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH   = 6,
    parameter int unsigned WMASK_WIDTH  = 2,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic [DATA_WIDTH-1:0]   seed,
    output logic                    we,
    output logic [WMASK_WIDTH-1:0]  wmask,
    output logic [ADDR_WIDTH-1:0]   addr,
    output logic [DATA_WIDTH-1:0]   din,
    input  logic [DATA_WIDTH-1:0]   dout,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH:0]     err_count,
    output logic                    err_flag,
    output logic [ADDR_WIDTH-1:0]   first_err_addr
);

    localparam int unsigned EXT_W   = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int unsigned ERR_W   = ADDR_WIDTH + 1;
    localparam int unsigned DRAIN_W = 4;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;
    localparam logic [ERR_W-1:0]      ERR_MAX    = '1;
    localparam logic [DRAIN_W-1:0]    DRAIN_LAST = DRAIN_W'(READ_LATENCY - 1);

    function automatic logic [DATA_WIDTH-1:0] pat(input logic [DATA_WIDTH-1:0] s,
                                                  input logic [ADDR_WIDTH-1:0] a);
        logic [EXT_W-1:0] ext;
        ext = EXT_W'(a);
        return s ^ ext[DATA_WIDTH-1:0];
    endfunction

    logic [2:0]             state, state_n;
    logic [ADDR_WIDTH-1:0]  cnt, cnt_n;
    logic [DRAIN_W-1:0]     drain_cnt, drain_n;
    logic [1:0]             mode_q, mode_n;
    logic [DATA_WIDTH-1:0]  seed_q, seed_n;
    logic                   start_ok_c;

    logic                   we_n, busy_n, done_n;
    logic [WMASK_WIDTH-1:0] wmask_n;
    logic [ADDR_WIDTH-1:0]  addr_n;
    logic [DATA_WIDTH-1:0]  din_n;

    // Next state, then the registered command outputs derived from it
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        drain_n    = drain_cnt;
        mode_n     = mode_q;
        seed_n     = seed_q;
        start_ok_c = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    start_ok_c = 1'b1;
                    mode_n     = mode;
                    seed_n     = seed;
                    cnt_n      = '0;
                    state_n    = (mode == 2'd1) ? S_READ : S_WRITE;
                end
            end
            S_WRITE: begin
                if (cnt == LAST_ADDR) begin
                    cnt_n   = '0;
                    state_n = (mode_q == 2'd0) ? S_DONE : S_READ;
                end else begin
                    cnt_n = cnt + ADDR_WIDTH'(1);
                end
            end
            S_READ: begin
                if (cnt == LAST_ADDR) begin
                    cnt_n   = '0;
                    drain_n = '0;
                    state_n = S_DRAIN;
                end else begin
                    cnt_n = cnt + ADDR_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) state_n = S_DONE;
                else                         drain_n = drain_cnt + DRAIN_W'(1);
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        we_n    = 1'b0;
        wmask_n = '0;
        addr_n  = '0;
        din_n   = '0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        case (state_n)
            S_WRITE: begin
                we_n    = 1'b1;
                wmask_n = '1;
                addr_n  = cnt_n;
                din_n   = pat(seed_n, cnt_n);
                busy_n  = 1'b1;
            end
            S_READ: begin
                addr_n = cnt_n;
                busy_n = 1'b1;
            end
            S_DRAIN: busy_n = 1'b1;
            S_DONE:  done_n = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            drain_cnt <= '0;
            mode_q    <= '0;
            seed_q    <= '0;
            we        <= 1'b0;
            wmask     <= '0;
            addr      <= '0;
            din       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            drain_cnt <= drain_n;
            mode_q    <= mode_n;
            seed_q    <= seed_n;
            we        <= we_n;
            wmask     <= wmask_n;
            addr      <= addr_n;
            din       <= din_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    // Expect pipeline: an entry pushed while a read address is on the bus reaches the end
    // in the cycle its data is valid on dout
    logic                  pipe_vld  [READ_LATENCY];
    logic [ADDR_WIDTH-1:0] pipe_addr [READ_LATENCY];
    logic [DATA_WIDTH-1:0] pipe_exp  [READ_LATENCY];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(READ_LATENCY); i++) pipe_vld[i] <= 1'b0;
        end else begin
            pipe_vld[0] <= (state == S_READ);
            for (int i = 1; i < int'(READ_LATENCY); i++) pipe_vld[i] <= pipe_vld[i-1];
        end
        pipe_addr[0] <= cnt;
        pipe_exp[0]  <= pat(seed_q, cnt);
        for (int i = 1; i < int'(READ_LATENCY); i++) begin
            pipe_addr[i] <= pipe_addr[i-1];
            pipe_exp[i]  <= pipe_exp[i-1];
        end
    end

    logic mismatch_c;
    assign mismatch_c = pipe_vld[READ_LATENCY-1] && (dout != pipe_exp[READ_LATENCY-1]);

    always_ff @(posedge clock) begin
        if (reset || start_ok_c) begin
            err_count      <= '0;
            err_flag       <= 1'b0;
            first_err_addr <= '0;
        end else if (mismatch_c) begin
            if (err_count != ERR_MAX) err_count <= err_count + ERR_W'(1);
            if (!err_flag) begin
                err_flag       <= 1'b1;
                first_err_addr <= pipe_addr[READ_LATENCY-1];
            end
        end
    end

endmodule

// File: tb/tb_sram_pattern_gen.sv
// Scoreboard bench for sram_pattern_gen: a behavioural SRAM (default build) and a
// stuck-at-0 SRAM (3-bit address, latency 5) driven by two instances.
module tb_sram_pattern_gen;

    localparam int unsigned DW = 4, AW = 6, WMW = 2, RL = 2, DEPTH = 64;
    localparam int unsigned AW2 = 3, RL2 = 5;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic           reset, start;
    logic [1:0]     mode;
    logic [DW-1:0]  seed;
    logic           we;
    logic [WMW-1:0] wmask;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  din, dout;
    logic           busy, done;
    logic [AW:0]    err_count;
    logic           err_flag;
    logic [AW-1:0]  first_err_addr;

    logic           s_start;
    logic [1:0]     s_mode;
    logic [DW-1:0]  s_seed;
    logic           s_we;
    logic [WMW-1:0] s_wmask;
    logic [AW2-1:0] s_addr;
    logic [DW-1:0]  s_din, s_dout;
    logic           s_busy, s_done;
    logic [AW2:0]   s_err_count;
    logic           s_err_flag;
    logic [AW2-1:0] s_first_err_addr;

    sram_pattern_gen u_dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode), .seed(seed),
        .we(we), .wmask(wmask), .addr(addr), .din(din), .dout(dout),
        .busy(busy), .done(done), .err_count(err_count), .err_flag(err_flag),
        .first_err_addr(first_err_addr)
    );

    sram_pattern_gen #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW2), .WMASK_WIDTH(WMW), .READ_LATENCY(RL2)) u_small (
        .clock(clock), .reset(reset), .start(s_start), .mode(s_mode), .seed(s_seed),
        .we(s_we), .wmask(s_wmask), .addr(s_addr), .din(s_din), .dout(s_dout),
        .busy(s_busy), .done(s_done), .err_count(s_err_count), .err_flag(s_err_flag),
        .first_err_addr(s_first_err_addr)
    );

    // Behavioural wrapper + macro: data for the address on the bus in cycle c is on dout in c+RL
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdq [RL];
    bit            flip_en;

    always @(posedge clock) begin
        if (we) mem[addr] <= din;
        rdq[0] <= mem[addr] ^ ((flip_en && (addr == 6'd5 || addr == 6'd40)) ? 4'b0001 : 4'b0000);
        for (int i = 1; i < int'(RL); i++) rdq[i] <= rdq[i-1];
    end
    assign dout   = rdq[RL-1];
    assign s_dout = '0;

    typedef struct { longint t; int ec; int fl; int fa; } res_t;
    typedef struct { int a; int d; } wr_t;
    res_t rq[$];
    res_t rq2[$];
    wr_t  wq[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Monitor: pops expected write beats and run results as the DUTs produce them
    wr_t  mw;
    res_t mr;
    always @(negedge clock) begin
        if (!reset) begin
            if (we) begin
                if (wq.size() == 0) check("unexpected_write", 1, 0);
                else begin
                    mw = wq.pop_front();
                    check("wr_addr", addr, mw.a);
                    check("wr_din", din, mw.d);
                    check("wr_mask", wmask, 3);
                end
            end
            if (done) begin
                if (rq.size() == 0) check("extra_done", 1, 0);
                else begin
                    mr = rq.pop_front();
                    check("done_time", $time, mr.t);
                    check("err_count", err_count, mr.ec);
                    check("err_flag", err_flag, mr.fl);
                    check("first_err_addr", first_err_addr, mr.fa);
                    check("busy_at_done", busy, 0);
                end
            end
            if (s_done) begin
                if (rq2.size() == 0) check("small_extra_done", 1, 0);
                else begin
                    mr = rq2.pop_front();
                    check("small_done_time", $time, mr.t);
                    check("small_err_count", s_err_count, mr.ec);
                    check("small_err_flag", s_err_flag, mr.fl);
                    check("small_first_err", s_first_err_addr, mr.fa);
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_we"}, we, 0);
        check({tag, "_wmask"}, wmask, 0);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_din"}, din, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err_count"}, err_count, 0);
        check({tag, "_err_flag"}, err_flag, 0);
        check({tag, "_first_err"}, first_err_addr, 0);
    endtask

    task automatic push_writes(input int sd);
        for (int a = 0; a < int'(DEPTH); a++) wq.push_back('{a, (sd ^ (a & 15)) & 15});
    endtask

    task automatic run_test(input int m, input int sd, input bit flip, input int ec,
                            input int fl, input int fa, input bit hold);
        int len;
        bit seen;
        len  = ((m != 1) ? int'(DEPTH) : 0) + ((m != 0) ? int'(DEPTH + RL) : 0) + 1;
        seen = 1'b0;
        @(negedge clock);
        if (m != 1) push_writes(sd);
        flip_en = flip;
        rq.push_back('{longint'($time) + longint'(len) * 10, ec, fl, fa});
        start = 1'b1;
        mode  = 2'(m);
        seed  = 4'(sd);
        if (!hold) begin
            @(negedge clock);
            start = 1'b0;
        end
        for (int i = 0; i < len + 20; i++) begin
            @(negedge clock);
            if (done) begin
                seen = 1'b1;
                if (hold) begin
                    @(posedge clock);
                    #1 start = 1'b0;
                end
                break;
            end
        end
        start = 1'b0;
        if (!seen) begin
            check("done_timeout", 0, 1);
            rq.delete();
            wq.delete();
        end
        repeat (3) @(negedge clock);
        check("idle_busy", busy, 0);
        check("idle_hold_err_count", err_count, ec);
        check("idle_we", we, 0);
    endtask

    task automatic run_small(input int sd, input int ec);
        bit seen;
        seen = 1'b0;
        @(negedge clock);
        rq2.push_back('{longint'($time) + 22 * 10, ec, (ec != 0) ? 1 : 0, 0});
        s_start = 1'b1;
        s_mode  = 2'd2;
        s_seed  = 4'(sd);
        @(negedge clock);
        s_start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (s_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check("small_done_timeout", 0, 1);
            rq2.delete();
        end
        repeat (2) @(negedge clock);
        check("small_hold_err_count", s_err_count, ec);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        mode    = '0;
        seed    = '0;
        flip_en = 1'b0;
        s_start = 1'b0;
        s_mode  = '0;
        s_seed  = '0;
        repeat (3) @(negedge clock);
        check_reset_vals("rst");
        reset = 1'b0;

        run_test(2, 'hA, 1'b0, 0, 0, 0, 1'b0);
        run_test(2, 'hA, 1'b1, 2, 1, 5, 1'b0);
        run_test(0, 3, 1'b0, 0, 0, 0, 1'b0);
        run_test(1, 3, 1'b0, 0, 0, 0, 1'b0);
        run_test(1, 4, 1'b0, 64, 1, 0, 1'b0);
        run_test(2, 5, 1'b0, 0, 0, 0, 1'b1);

        // Reset on the 20th cycle of the read sweep
        @(negedge clock);
        push_writes(6);
        start = 1'b1;
        mode  = 2'd2;
        seed  = 4'd6;
        @(negedge clock);
        start = 1'b0;
        repeat (83) @(negedge clock);
        check("mid_read_addr", addr, 19);
        check("mid_read_busy", busy, 1);
        reset = 1'b1;
        @(negedge clock);
        check_reset_vals("midrst");
        reset = 1'b0;
        wq.delete();
        repeat (5) @(negedge clock);
        check("post_reset_no_done", done, 0);
        run_test(2, 9, 1'b0, 0, 0, 0, 1'b0);

        // Stuck-at-0 memory: seed C never yields zero; seed 5 yields zero only at a=5
        run_small('hC, 8);
        run_small(5, 7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
